rtc_time_keeper: RTL and testbench

RTC_TIME_KEEPER -- requirements
Module: rtc_time_keeper

---
 rtl/rtc_time_keeper.sv | 129 ++++++++++++
 tb/tb_rtc_time_keeper.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_keeper.sv
// Real-time clock core: a programmable prescaler produces a one-second tick
// that advances a 24-hour sec/min/hour counter. The block also provides a
// validated time-load path and a 12/24-hour display conversion.
module rtc_time_keeper #(
  parameter int unsigned P_COUNT_BIT = 30,
  parameter int unsigned P_SEC_BIT   = 6,
  parameter int unsigned P_MIN_BIT   = 6,
  parameter int unsigned P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_mode_12h,
  input  logic                   i_load,
  input  logic [P_SEC_BIT-1:0]   i_load_sec,
  input  logic [P_MIN_BIT-1:0]   i_load_min,
  input  logic [P_HOUR_BIT-1:0]  i_load_hour,
  output logic                   o_tick,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic                   o_pm,
  output logic                   o_day_tick,
  output logic                   o_load_err
);

  logic [P_COUNT_BIT-1:0] count_q;
  logic [P_COUNT_BIT-1:0] count_last;
  logic                   tick_q;
  logic                   day_tick_q;
  logic                   load_err_q;
  logic [P_SEC_BIT-1:0]   sec_q, sec_adv;
  logic [P_MIN_BIT-1:0]   min_q, min_adv;
  logic [P_HOUR_BIT-1:0]  hour_q, hour_adv;
  logic                   day_wrap;
  logic                   load_ok;

  // i_freq == 0 behaves like i_freq == 1 (tick every cycle).
  assign count_last = (i_freq == '0) ? '0 : i_freq - P_COUNT_BIT'(1);

  // Load values are checked at 32-bit unsigned width so no bits are lost.
  assign load_ok = (32'(i_load_sec) < 32'd60) && (32'(i_load_min) < 32'd60) &&
                   (32'(i_load_hour) < 32'd24);

  // Candidate time one second ahead, with sec->min->hour->day carries.
  always_comb begin
    sec_adv  = sec_q + P_SEC_BIT'(1);
    min_adv  = min_q;
    hour_adv = hour_q;
    day_wrap = 1'b0;
    if (sec_q >= P_SEC_BIT'(59)) begin
      sec_adv = '0;
      if (min_q >= P_MIN_BIT'(59)) begin
        min_adv = '0;
        if (hour_q >= P_HOUR_BIT'(23)) begin
          hour_adv = '0;
          day_wrap = 1'b1;
        end else begin
          hour_adv = hour_q + P_HOUR_BIT'(1);
        end
      end else begin
        min_adv = min_q + P_MIN_BIT'(1);
      end
    end
  end

  // Prescaler, time registers and status pulses; a valid load wins over a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
    end else begin
      load_err_q <= i_load && !load_ok;
      day_tick_q <= 1'b0;
      if (i_load && load_ok) begin
        sec_q   <= i_load_sec;
        min_q   <= i_load_min;
        hour_q  <= i_load_hour;
        count_q <= '0;
        tick_q  <= 1'b0;
      end else begin
        if (tick_q) begin
          sec_q      <= sec_adv;
          min_q      <= min_adv;
          hour_q     <= hour_adv;
          day_tick_q <= day_wrap;
        end
        if (i_run_en) begin
          // >= also catches a count stranded above a freshly lowered i_freq.
          if (count_q >= count_last) begin
            count_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            count_q <= count_q + P_COUNT_BIT'(1);
            tick_q  <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end
  end

  // Display hour: stored time is always 24-hour, only the view changes.
  always_comb begin
    o_hour = hour_q;
    if (i_mode_12h) begin
      if (hour_q == '0) begin
        o_hour = P_HOUR_BIT'(12);
      end else if (hour_q > P_HOUR_BIT'(12)) begin
        o_hour = hour_q - P_HOUR_BIT'(12);
      end
    end
  end

  assign o_pm       = (hour_q >= P_HOUR_BIT'(12));
  assign o_tick     = tick_q;
  assign o_day_tick = day_tick_q;
  assign o_load_err = load_err_q;
  assign o_sec      = sec_q;
  assign o_min      = min_q;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Directed bench for rtc_time_keeper: one task per scenario, inline checks.
module tb_rtc_time_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run_en;
  logic [29:0] i_freq;
  logic        i_mode_12h;
  logic        i_load;
  logic [5:0]  i_load_sec;
  logic [5:0]  i_load_min;
  logic [4:0]  i_load_hour;
  logic        o_tick;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic [4:0]  o_hour;
  logic        o_pm;
  logic        o_day_tick;
  logic        o_load_err;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_time_keeper dut (
    .clk        (clk),
    .reset      (reset),
    .i_run_en   (i_run_en),
    .i_freq     (i_freq),
    .i_mode_12h (i_mode_12h),
    .i_load     (i_load),
    .i_load_sec (i_load_sec),
    .i_load_min (i_load_min),
    .i_load_hour(i_load_hour),
    .o_tick     (o_tick),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_pm       (o_pm),
    .o_day_tick (o_day_tick),
    .o_load_err (o_load_err)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of valid-or-invalid load with the given values.
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    i_load = 1'b1; i_load_hour = h; i_load_min = m; i_load_sec = s;
    step();
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_run_en = 1'b1; i_freq = 30'd1; i_mode_12h = 1'b0;
    i_load = 1'b1; i_load_hour = 5'd12; i_load_min = 6'd34; i_load_sec = 6'd56;
    step();
    step();
    n_checks++;
    if ({o_hour, o_min, o_sec} !== 17'd0) begin
      n_fail++; $display("FAIL reset_time got=%0d:%0d:%0d want=0:0:0", o_hour, o_min, o_sec);
    end
    n_checks++;
    if ({o_tick, o_day_tick, o_load_err, o_pm} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b%b%b%b want=0000", o_tick, o_day_tick, o_load_err, o_pm);
    end
    i_mode_12h = 1'b1;
    #1;
    n_checks++;
    if (o_hour !== 5'd12) begin
      n_fail++; $display("FAIL reset_hour_12h got=%0d want=12", o_hour);
    end
    i_mode_12h = 1'b0;
    i_load = 1'b0;
  endtask

  task automatic test_basic_tick();
    i_freq = 30'd5; i_run_en = 1'b1; reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      n_checks++;
      if (o_tick !== ((e % 5) == 0)) begin
        n_fail++; $display("FAIL basic_tick edge=%0d got=%b want=%b", e, o_tick, (e % 5) == 0);
      end
      if (e == 6) begin
        n_checks++;
        if (o_sec !== 6'd1) begin
          n_fail++; $display("FAIL basic_sec1 got=%0d want=1", o_sec);
        end
      end
    end
    n_checks++;
    if (o_sec !== 6'd3) begin
      n_fail++; $display("FAIL basic_sec3 got=%0d want=3", o_sec);
    end
  endtask

  // Run gating followed by a valid load landing on a tick cycle.
  task automatic test_run_gate_and_collision();
    do_load(5'd1, 6'd2, 6'd3);   // count = 0
    step();
    step();                      // count = 2
    i_run_en = 1'b0;
    for (int e = 0; e < 7; e++) begin
      step();
      n_checks++;
      if (o_tick !== 1'b0) begin
        n_fail++; $display("FAIL gate_no_tick cyc=%0d got=%b want=0", e, o_tick);
      end
    end
    n_checks++;
    if (o_sec !== 6'd3) begin
      n_fail++; $display("FAIL gate_sec_hold got=%0d want=3", o_sec);
    end
    i_run_en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_checks++;
      if (o_tick !== (e == 3)) begin
        n_fail++; $display("FAIL gate_resume edge=%0d got=%b want=%b", e, o_tick, e == 3);
      end
    end
    // o_tick is high now: collide a valid load with it.
    do_load(5'd5, 6'd30, 6'd20);
    n_checks++;
    if ({o_hour, o_min, o_sec, o_tick} !== {5'd5, 6'd30, 6'd20, 1'b0}) begin
      n_fail++;
      $display("FAIL collide_load got=%0d:%0d:%0d tick=%b want=5:30:20 tick=0",
               o_hour, o_min, o_sec, o_tick);
    end
    for (int e = 1; e <= 5; e++) begin
      step();
      n_checks++;
      if (o_tick !== (e == 5)) begin
        n_fail++; $display("FAIL collide_next_tick edge=%0d got=%b want=%b", e, o_tick, e == 5);
      end
    end
    step();
    n_checks++;
    if (o_sec !== 6'd21) begin
      n_fail++; $display("FAIL collide_advance got=%0d want=21", o_sec);
    end
  endtask

  task automatic test_reset_mid();
    do_load(5'd5, 6'd30, 6'd20);
    step(); step(); step();      // count = 3
    reset = 1'b1;
    step();
    n_checks++;
    if ({o_hour, o_min, o_sec, o_tick, o_day_tick, o_load_err, o_pm} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%0d:%0d:%0d flags=%b%b%b%b want=0:0:0 flags=0000",
               o_hour, o_min, o_sec, o_tick, o_day_tick, o_load_err, o_pm);
    end
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_checks++;
      if (o_tick !== (e == 5)) begin
        n_fail++; $display("FAIL reset_mid_tick edge=%0d got=%b want=%b", e, o_tick, e == 5);
      end
    end
  endtask

  task automatic test_rollover();
    i_freq = 30'd2;
    do_load(5'd23, 6'd59, 6'd58);
    n_checks++;
    if (o_pm !== 1'b1) begin
      n_fail++; $display("FAIL roll_pm_before got=%b want=1", o_pm);
    end
    for (int e = 1; e <= 6; e++) begin
      step();
      n_checks++;
      if (o_day_tick !== (e == 5)) begin
        n_fail++; $display("FAIL roll_day_tick edge=%0d got=%b want=%b", e, o_day_tick, e == 5);
      end
      if (e == 5) begin
        n_checks++;
        if ({o_hour, o_min, o_sec, o_pm} !== 18'd0) begin
          n_fail++;
          $display("FAIL roll_time got=%0d:%0d:%0d pm=%b want=0:0:0 pm=0",
                   o_hour, o_min, o_sec, o_pm);
        end
      end
    end
  endtask

  task automatic test_mode_12h();
    i_run_en = 1'b0; i_mode_12h = 1'b1;
    do_load(5'd0, 6'd0, 6'd0);
    n_checks++;
    if ({o_hour, o_pm} !== {5'd12, 1'b0}) begin
      n_fail++; $display("FAIL h12_midnight got=%0d pm=%b want=12 pm=0", o_hour, o_pm);
    end
    do_load(5'd12, 6'd0, 6'd0);
    n_checks++;
    if ({o_hour, o_pm} !== {5'd12, 1'b1}) begin
      n_fail++; $display("FAIL h12_noon got=%0d pm=%b want=12 pm=1", o_hour, o_pm);
    end
    do_load(5'd13, 6'd0, 6'd7);
    n_checks++;
    if ({o_hour, o_pm} !== {5'd1, 1'b1}) begin
      n_fail++; $display("FAIL h12_13 got=%0d pm=%b want=1 pm=1", o_hour, o_pm);
    end
    i_mode_12h = 1'b0;
    step();
    n_checks++;
    if ({o_hour, o_sec, o_pm} !== {5'd13, 6'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL h12_toggle got=%0d sec=%0d pm=%b want=13 sec=7 pm=1", o_hour, o_sec, o_pm);
    end
  endtask

  task automatic test_invalid_load();
    // Time is 13:00:07, run off, count = 0.
    do_load(5'd10, 6'd60, 6'd0);
    n_checks++;
    if ({o_load_err, o_hour, o_min, o_sec} !== {1'b1, 5'd13, 6'd0, 6'd7}) begin
      n_fail++;
      $display("FAIL bad_load got=err%b %0d:%0d:%0d want=err1 13:0:7",
               o_load_err, o_hour, o_min, o_sec);
    end
    step();
    n_checks++;
    if (o_load_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_load_pulse got=%b want=0", o_load_err);
    end
    i_freq = 30'd2; i_run_en = 1'b1;
    step();
    step();
    n_checks++;
    if (o_tick !== 1'b1) begin
      n_fail++; $display("FAIL bad_load_pre_tick got=%b want=1", o_tick);
    end
    do_load(5'd24, 6'd0, 6'd0);
    n_checks++;
    if ({o_load_err, o_sec, o_hour} !== {1'b1, 6'd8, 5'd13}) begin
      n_fail++;
      $display("FAIL bad_load_on_tick got=err%b sec=%0d hour=%0d want=err1 sec=8 hour=13",
               o_load_err, o_sec, o_hour);
    end
  endtask

  task automatic test_freq_edges();
    // Lowering i_freq below the current count forces an immediate wrap.
    i_freq = 30'd10;
    do_load(5'd0, 6'd0, 6'd0);
    for (int e = 0; e < 6; e++) step();
    n_checks++;
    if (o_tick !== 1'b0) begin
      n_fail++; $display("FAIL freq_pre got=%b want=0", o_tick);
    end
    i_freq = 30'd3;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_checks++;
      if (o_tick !== (e == 1 || e == 4)) begin
        n_fail++;
        $display("FAIL freq_shrink edge=%0d got=%b want=%b", e, o_tick, e == 1 || e == 4);
      end
    end
    // i_freq = 0 behaves as 1: tick high every cycle.
    i_freq = 30'd0;
    do_load(5'd0, 6'd0, 6'd0);
    for (int e = 1; e <= 4; e++) begin
      step();
      n_checks++;
      if (o_tick !== 1'b1) begin
        n_fail++; $display("FAIL freq_zero edge=%0d got=%b want=1", e, o_tick);
      end
    end
    n_checks++;
    if (o_sec !== 6'd3) begin
      n_fail++; $display("FAIL freq_zero_sec got=%0d want=3", o_sec);
    end
  endtask

  initial begin
    reset = 1'b1; i_run_en = 1'b0; i_freq = '0; i_mode_12h = 1'b0;
    i_load = 1'b0; i_load_sec = '0; i_load_min = '0; i_load_hour = '0;
    test_reset();
    test_basic_tick();
    test_run_gate_and_collision();
    test_reset_mid();
    test_rollover();
    test_mode_12h();
    test_invalid_load();
    test_freq_edges();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
